fft_out_serializer: RTL and testbench

- Back end of the 16-point FFT datapath.
- When the stage sequencer's cycle-done flag rises, it captures the N parallel complex results from the last butterfly stage.
- It streams them out one bin per beat, in natural frequency order, over a valid/ready interface.
- It undoes the bit-reversed bin placement of the radix-2 pipeline.

---
 rtl/fft_out_serializer.sv | 73 +++++++
 tb/tb_fft_out_serializer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures N parallel FFT bins on a load edge and streams them out in natural order over valid/ready
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load capture request (rising edge acts);
//        i_re/i_im packed slot results; i_ready downstream accept; o_valid/o_re/o_im/o_index current beat;
//        o_first/o_last frame markers; o_busy frame held; o_overrun one-cycle pulse for a dropped load edge
module fft_out_serializer #(
  parameter int N = 16,
  parameter int DATA_W = 16,
  parameter int BITREV = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [N*DATA_W-1:0]     i_re,
  input  logic [N*DATA_W-1:0]     i_im,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [DATA_W-1:0]       o_re,
  output logic [DATA_W-1:0]       o_im,
  output logic [$clog2(N)-1:0]    o_index,
  output logic                    o_first,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_overrun
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t r_state, w_state_next;
  logic [IW-1:0] r_idx, w_idx_next, w_rev, w_slot;
  logic r_load_d, r_overrun, w_load_edge, w_xfer, w_last, w_end, w_capture, w_drop;
  logic [N*DATA_W-1:0] r_re, r_im;
  assign w_load_edge = i_load & ~r_load_d;
  assign w_xfer = (r_state == STREAM) & i_ready;
  assign w_last = r_idx == IW'(N - 1);
  assign w_end = w_xfer & w_last;
  // a load edge coinciding with the accepted final beat starts the next frame without a bubble
  assign w_capture = w_load_edge & ((r_state == IDLE) | w_end);
  assign w_drop = w_load_edge & (r_state == STREAM) & ~w_end;
  always_comb begin
    w_state_next = w_capture ? STREAM : w_end ? IDLE : r_state;
    w_idx_next = w_capture ? '0 : (w_xfer & ~w_last) ? r_idx + 1'b1 : r_idx;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_load_d <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx <= w_idx_next;
      r_load_d <= i_load;
      r_overrun <= w_drop;
    end
  always_ff @(posedge i_clk)
    if (w_capture) begin
      r_re <= i_re;
      r_im <= i_im;
    end
  // the radix-2 pipeline leaves bin b in slot bitrev(b), so reading slot bitrev(idx) yields natural order
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < IW; i++) w_rev[i] = r_idx[IW-1-i];
  end
  assign w_slot = (BITREV != 0) ? w_rev : r_idx;
  assign o_valid = r_state == STREAM;
  assign o_busy = o_valid;
  assign o_index = o_valid ? r_idx : '0;
  assign o_re = o_valid ? r_re[int'(w_slot)*DATA_W +: DATA_W] : '0;
  assign o_im = o_valid ? r_im[int'(w_slot)*DATA_W +: DATA_W] : '0;
  assign o_first = o_valid & (r_idx == '0);
  assign o_last = o_valid & w_last;
  assign o_overrun = r_overrun;
endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: table-driven check of the FFT output serializer in bit-reversed and natural modes
module tb_fft_out_serializer;
  logic clk = 1'b0;
  logic rst_n, load, ready;
  logic [255:0] re, im;
  logic v1, f1, l1, b1, ov1, v0, f0, l0, b0, ov0;
  logic [15:0] re1, im1, re0, im0;
  logic [3:0] ix1, ix0;
  int n_vec = 0;
  int n_err = 0;
  int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  typedef struct {
    logic ld;
    logic rdy;
    int db;
    logic ev;
    logic [3:0] ei;
    logic [15:0] ere;
    logic [15:0] eim;
    logic [15:0] e0re;
    logic eov;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  fft_out_serializer #(.N(16), .DATA_W(16), .BITREV(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_re(re), .i_im(im), .i_ready(ready),
    .o_valid(v1), .o_re(re1), .o_im(im1), .o_index(ix1), .o_first(f1), .o_last(l1),
    .o_busy(b1), .o_overrun(ov1));
  fft_out_serializer #(.N(16), .DATA_W(16), .BITREV(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_re(re), .i_im(im), .i_ready(ready),
    .o_valid(v0), .o_re(re0), .o_im(im0), .o_index(ix0), .o_first(f0), .o_last(l0),
    .o_busy(b0), .o_overrun(ov0));
  task automatic chk(input string nm, input int n, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, n, got, exp);
    end
  endtask
  task automatic set_data(input int b);
    for (int k = 0; k < 16; k++) begin
      re[k*16 +: 16] = 16'(b + k);
      im[k*16 +: 16] = 16'(-k);
    end
  endtask
  task automatic pv(input logic ld, input logic rdy, input int db, input logic ev, input int ei, input int eb, input logic eov);
    vec_t v;
    v.ld = ld;
    v.rdy = rdy;
    v.db = db;
    v.ev = ev;
    v.ei = ev ? 4'(ei) : 4'd0;
    v.ere = ev ? 16'(eb + br[ei]) : 16'd0;
    v.eim = ev ? 16'(-br[ei]) : 16'd0;
    v.e0re = ev ? 16'(eb + ei) : 16'd0;
    v.eov = eov;
    tv.push_back(v);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, n_vec, {31'd0, v1}, 0);
    chk({nm, "_busy"}, n_vec, {31'd0, b1}, 0);
    chk({nm, "_index"}, n_vec, {28'd0, ix1}, 0);
    chk({nm, "_re"}, n_vec, {16'd0, re1}, 0);
    chk({nm, "_im"}, n_vec, {16'd0, im1}, 0);
    chk({nm, "_first"}, n_vec, {31'd0, f1}, 0);
    chk({nm, "_last"}, n_vec, {31'd0, l1}, 0);
    chk({nm, "_ovr"}, n_vec, {31'd0, ov1}, 0);
    chk({nm, "_valid0"}, n_vec, {31'd0, v0}, 0);
    chk({nm, "_re0"}, n_vec, {16'd0, re0}, 0);
    n_vec++;
  endtask
  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    ready = 1'b0;
    set_data(100);
    pv(0, 1, 100, 0, 0, 0, 0);
    pv(1, 1, 100, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) pv(1, 1, 100, 1, j, 100, 0);
    pv(1, 1, 100, 0, 0, 0, 0);
    pv(1, 1, 100, 0, 0, 0, 0);
    pv(0, 1, 100, 0, 0, 0, 0);
    pv(1, 1, 100, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) begin
      if (j == 3 || j == 9) repeat (4) pv(0, 0, 100, 1, j, 100, 0);
      pv(0, 1, 100, 1, j, 100, 0);
    end
    pv(0, 1, 0, 0, 0, 0, 0);
    pv(1, 1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) pv(0, 1, 0, 1, j, 0, 0);
    pv(0, 1, 100, 0, 0, 0, 0);
    pv(1, 1, 100, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) pv(j == 5, 1, (j >= 5) ? 300 : 100, 1, j, 100, j == 6);
    pv(0, 1, 300, 0, 0, 0, 0);
    pv(0, 1, 100, 0, 0, 0, 0);
    pv(1, 1, 100, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) pv(j == 15, 1, (j == 15) ? 200 : 100, 1, j, 100, 0);
    for (int j = 0; j < 16; j++) pv(0, 1, 200, 1, j, 200, 0);
    pv(0, 1, 100, 0, 0, 0, 0);
    pv(1, 1, 100, 0, 0, 0, 0);
    for (int j = 0; j < 7; j++) pv(0, 1, 100, 1, j, 100, 0);
    #1;
    chk_zero("reset");
    @(negedge clk);
    chk_zero("reset_hold");
    rst_n = 1'b1;
    foreach (tv[n]) begin
      @(negedge clk);
      chk("valid", n, {31'd0, v1}, {31'd0, tv[n].ev});
      chk("busy", n, {31'd0, b1}, {31'd0, tv[n].ev});
      chk("index", n, {28'd0, ix1}, {28'd0, tv[n].ei});
      chk("re", n, {16'd0, re1}, {16'd0, tv[n].ere});
      chk("im", n, {16'd0, im1}, {16'd0, tv[n].eim});
      chk("first", n, {31'd0, f1}, {31'd0, tv[n].ev && tv[n].ei == 4'd0});
      chk("last", n, {31'd0, l1}, {31'd0, tv[n].ev && tv[n].ei == 4'd15});
      chk("overrun", n, {31'd0, ov1}, {31'd0, tv[n].eov});
      chk("valid0", n, {31'd0, v0}, {31'd0, tv[n].ev});
      chk("index0", n, {28'd0, ix0}, {28'd0, tv[n].ei});
      chk("re0", n, {16'd0, re0}, {16'd0, tv[n].e0re});
      load = tv[n].ld;
      ready = tv[n].rdy;
      set_data(tv[n].db);
      n_vec++;
    end
    @(negedge clk);
    chk("mid_valid", n_vec, {31'd0, v1}, 1);
    chk("mid_index", n_vec, {28'd0, ix1}, 7);
    chk("mid_re", n_vec, {16'd0, re1}, 114);
    n_vec++;
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    load = 1'b1;
    ready = 1'b1;
    set_data(500);
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_valid", n_vec, {31'd0, v1}, 1);
    chk("post_index", n_vec, {28'd0, ix1}, 0);
    chk("post_re", n_vec, {16'd0, re1}, 500);
    chk("post_first", n_vec, {31'd0, f1}, 1);
    n_vec++;
    @(negedge clk);
    chk("post_index1", n_vec, {28'd0, ix1}, 1);
    chk("post_re1", n_vec, {16'd0, re1}, 508);
    chk("post_re0", n_vec, {16'd0, re0}, 501);
    n_vec++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
